mdu_seq: RTL and testbench
==========================

# mdu_seq

Sequencer for the RV32 M-extension unit. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation from the EX stage and drives a single-cycle multiplier or a 32-step radix-2 restoring divider. It produces one result with its destination register tag, and backpressures EX through `in_ready` while busy. It sits beside the ALU in EX; its result joins the EX→MEM forwarding path as an alternate EX result.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operation present (EX decoded opcode R with funct7 = `M_INSTR`).
- `in_ready`  out  1  unit can accept; an operation is accepted on a rising edge with `in_valid && in_ready && !flush`.
- `in_funct3`  in  3  operation select, using the package `MUL`..`REMU` encodings.
- `in_rs1`, `in_rs2`  in  XLEN  operands, sampled only at accept.
- `in_rd`  in  5 (`r_t`)  destination tag, sampled at accept.
- `flush`  in  1  synchronous kill from branch or jump resolution.
- `out_valid`  out  1  one-cycle pulse; result valid.
- `out_result`  out  XLEN  result; holds until the next `out_valid`.
- `out_rd`  out  5 (`r_t`)  tag of the result; holds with `out_result`.
- `busy`  out  1  operation in flight (= `!in_ready`).

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE. `in_ready` = (state == IDLE).
- IDLE, on accept:
  - Latch funct3, rd and operands.
  - `funct3[2]` = 0 → MUL.
  - Divide with rs2 = 0 → DONE directly. DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU remainder = rs1.
  - DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF → DONE directly. Quotient = 0x80000000; remainder = 0.
  - Other divides → DIV. For signed ops, latch |rs1| and |rs2|. Record quotient sign = sign1 ^ sign2 and remainder sign = sign1. Iteration counter = 31.
- MUL:
  - Form the 64-bit product of 33-bit extended operands. Sign-extend rs1 for MULH/MULHSU; sign-extend rs2 for MULH only.
  - MUL selects product[31:0]; the others select [63:32].
  - Register the selection into `out_result` → DONE.
- DIV:
  - Each cycle performs one restoring step: rem = {rem[30:0], dvd[31]}; if rem ≥ divisor, subtract and shift in quotient bit 1, else 0.
  - Counter decrements; leave for FIX after the step with counter = 0, giving exactly 32 steps.
- FIX:
  - Apply the sign corrections (two's-complement negate) for signed ops.
  - Select the quotient for DIV/DIVU, or the remainder for REM/REMU, into `out_result` → DONE.
- DONE: `out_valid` = 1 for this cycle only → IDLE.
- `flush` in any state → IDLE on the next edge. No `out_valid` is produced; `out_result`/`out_rd` keep their old values. `flush` in IDLE with `in_valid` high blocks the accept.
- `flush` in DONE suppresses that `out_valid`.
- `rst_n` low at any time, including mid-divide:
  - State returns to IDLE asynchronously.
  - `out_valid` = 0, `out_result` = 0, `out_rd` = X0, `in_ready` = 1, `busy` = 0, counter = 0.

## Timing
- Cycle 0 is the accept edge; `in_ready` falls in cycle 1.
- Multiply: `out_valid` in cycle 2.
- Divide, normal case: DIV in cycles 1–32, FIX in 33, `out_valid` in cycle 34.
- Divide by zero or signed overflow: `out_valid` in cycle 1.
- `in_ready` rises in the cycle after `out_valid`. No back-to-back accept in the `out_valid` cycle.
- Minimum issue interval is 3 cycles for a multiply and 35 for a normal divide.
- No combinational path from `in_*` to `out_*`; all outputs are registered or decoded from state.

## Structure
- Add to the shared `defines` package:
  - `mdu_state_t` enum.
  - `MDU_MUL_LAT` = 2 and `MDU_DIV_LAT` = 34.
  - `DIV_ZERO_Q` = 32'hFFFF_FFFF and `DIV_OVF_Q` = 32'h8000_0000.
- Reuse the existing `funct3_t`, `r_t`, `data_t`, and the `MUL`..`REMU` localparams.
- One natural sub-module, `mdu_div_step`: combinational single restoring iteration.
  - Inputs: rem, dvd, divisor.
  - Outputs: next rem, next dvd, quotient bit.
  - Instantiated once and driven by the FSM registers.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `out_result` = 0xFFFFFFEB, `out_rd` as issued, `out_valid` in cycle 2, `in_ready` high in cycle 3.
- MULH, MULHSU and MULHU with 0x80000000 × 0x80000000:
  - MULH → 0x40000000.
  - MULHSU → 0xC0000000.
  - MULHU → 0x40000000.
- DIV −7/2 → 0xFFFFFFFD and REM −7/2 → 0xFFFFFFFF, both at cycle 34.
- DIVU 100/7 → 14 and REMU 100/7 → 2.
- DIVU 0x1234/0 → 0xFFFFFFFF and REMU 0x1234/0 → 0x1234, at cycle 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, at cycle 1.
- Flush during divide:
  - `flush` pulsed in cycle 10 of a divide → no `out_valid`, `in_ready` = 1 next cycle.
  - A following MUL 3 × 5 → 15 at cycle 2.
  - `flush` asserted together with `in_valid` in IDLE → no accept.
- Reset mid-divide: `rst_n` low in cycle 20 → all outputs at their reset values immediately. After release, DIVU 9/3 → 3 at cycle 34.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: shared types, funct3 encodings and constants for the M-extension sequencer
package mdu_seq_pkg;
  localparam int XLEN = 32;
  typedef logic [2:0] funct3_t;
  typedef logic [4:0] r_t;
  typedef logic [XLEN-1:0] data_t;
  localparam funct3_t MUL    = 3'b000;
  localparam funct3_t MULH   = 3'b001;
  localparam funct3_t MULHSU = 3'b010;
  localparam funct3_t MULHU  = 3'b011;
  localparam funct3_t DIV    = 3'b100;
  localparam funct3_t DIVU   = 3'b101;
  localparam funct3_t REM    = 3'b110;
  localparam funct3_t REMU   = 3'b111;
  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} mdu_state_t;
  localparam int MDU_MUL_LAT = 2;
  localparam int MDU_DIV_LAT = 34;
  localparam data_t DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam data_t DIV_OVF_Q  = 32'h8000_0000;
endpackage

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: EX-stage issue and result bus for the M-extension sequencer
interface mdu_seq_if;
  import mdu_seq_pkg::*;
  logic in_valid, in_ready, flush, out_valid, busy;
  funct3_t in_funct3;
  data_t in_rs1, in_rs2, out_result;
  r_t in_rd, out_rd;
  modport master (output in_valid, in_funct3, in_rs1, in_rs2, in_rd, flush,
                  input in_ready, out_valid, out_result, out_rd, busy);
  modport slave (input in_valid, in_funct3, in_rs1, in_rs2, in_rd, flush,
                 output in_ready, out_valid, out_result, out_rd, busy);
endinterface

// File: rtl/mdu_div_step.sv
// mdu_div_step: one radix-2 restoring division iteration
module mdu_div_step import mdu_seq_pkg::*; (
  input  data_t rem,
  input  data_t dvd,
  input  data_t divisor,
  output data_t rem_next,
  output data_t dvd_next,
  output logic  q_bit
);
  logic [32:0] t;
  assign t = {rem, dvd[31]};
  assign q_bit = t >= {1'b0, divisor};
  // the difference always fits in 32 bits because rem < divisor on entry
  assign rem_next = q_bit ? t[31:0] - divisor : t[31:0];
  assign dvd_next = {dvd[30:0], 1'b0};
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: sequencer for the RV32 M-extension; single-cycle multiply, 32-step restoring divide
module mdu_seq import mdu_seq_pkg::*; (
  input logic clk,
  input logic rst_n,
  mdu_seq_if.slave m
);
  mdu_state_t state;
  logic [1:0] op;
  r_t rd;
  data_t a, b, rem, rem_n, dvd_n, rs1_abs, rs2_abs, mul_sel, fix_sel;
  logic neg_q, neg_r, q_bit, sdiv, div_zero, div_ovf;
  logic [4:0] cnt;
  logic signed [32:0] xa, xb;
  logic signed [63:0] prod;
  assign sdiv = m.in_funct3[2] && !m.in_funct3[0];
  assign div_zero = m.in_rs2 == '0;
  assign div_ovf = sdiv && m.in_rs1 == DIV_OVF_Q && m.in_rs2 == '1;
  // multiplies never set sdiv, so the raw operands pass straight through
  assign rs1_abs = sdiv && m.in_rs1[31] ? -m.in_rs1 : m.in_rs1;
  assign rs2_abs = sdiv && m.in_rs2[31] ? -m.in_rs2 : m.in_rs2;
  assign xa = {(op[1] ^ op[0]) & a[31], a};
  assign xb = {(op == 2'b01) & b[31], b};
  assign prod = 64'(xa) * 64'(xb);
  assign mul_sel = op == 2'b00 ? prod[31:0] : prod[63:32];
  assign fix_sel = op[1] ? (neg_r ? -rem : rem) : (neg_q ? -a : a);
  assign m.in_ready = state == ST_IDLE;
  assign m.busy = state != ST_IDLE;
  assign m.out_valid = state == ST_DONE && !m.flush;
  mdu_div_step u_step (.rem(rem), .dvd(a), .divisor(b), .rem_next(rem_n), .dvd_next(dvd_n), .q_bit(q_bit));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op <= '0;
      rd <= '0;
      a <= '0;
      b <= '0;
      rem <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt <= '0;
      m.out_result <= '0;
      m.out_rd <= '0;
    end else if (m.flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (m.in_valid) begin
          op <= m.in_funct3[1:0];
          rd <= m.in_rd;
          a <= rs1_abs;
          b <= rs2_abs;
          rem <= '0;
          cnt <= 5'd31;
          neg_q <= sdiv && (m.in_rs1[31] ^ m.in_rs2[31]);
          neg_r <= sdiv && m.in_rs1[31];
          if (!m.in_funct3[2]) state <= ST_MUL;
          else if (div_zero || div_ovf) begin
            m.out_result <= div_zero ? (m.in_funct3[1] ? m.in_rs1 : DIV_ZERO_Q)
                                     : (m.in_funct3[1] ? '0 : DIV_OVF_Q);
            m.out_rd <= m.in_rd;
            state <= ST_DONE;
          end else state <= ST_DIV;
        end
        ST_MUL: begin
          m.out_result <= mul_sel;
          m.out_rd <= rd;
          state <= ST_DONE;
        end
        ST_DIV: begin
          rem <= rem_n;
          a <= dvd_n | data_t'(q_bit);
          cnt <= cnt - 5'd1;
          if (cnt == '0) state <= ST_FIX;
        end
        ST_FIX: begin
          m.out_result <= fix_sel;
          m.out_rd <= rd;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq
module tb_mdu_seq;
  import mdu_seq_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  mdu_seq_if bus();
  mdu_seq u_dut (.clk(clk), .rst_n(rst_n), .m(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input funct3_t f, input data_t x, input data_t y,
                     input r_t rd, input data_t exp, input int lat);
    int n;
    @(negedge clk);
    chk({tag, "_ready_before"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_funct3 = f;
    bus.in_rs1 = x;
    bus.in_rs2 = y;
    bus.in_rd = rd;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_rs1 = $urandom();
    bus.in_rs2 = $urandom();
    bus.in_rd = r_t'($urandom());
    n = 1;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_result"}, bus.out_result, exp);
    chk({tag, "_rd"}, 32'(bus.out_rd), 32'(rd));
    @(negedge clk);
    chk({tag, "_valid_pulse"}, 32'(bus.out_valid), 0);
    chk({tag, "_ready_after"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.in_funct3 = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_rd = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_result", bus.out_result, 0);
    chk("rst_rd", 32'(bus.out_rd), 0);
    rst_n = 1'b1;

    run("mul", MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MDU_MUL_LAT);
    run("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, MDU_MUL_LAT);
    run("mulhsu", MULHSU, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'hC000_0000, MDU_MUL_LAT);
    run("mulhu", MULHU, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'h4000_0000, MDU_MUL_LAT);
    run("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, MDU_DIV_LAT);
    run("rem_neg", REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, MDU_DIV_LAT);
    run("div_negdvs", DIV, 32'd100, 32'hFFFF_FFF9, 5'd11, 32'hFFFF_FFF2, MDU_DIV_LAT);
    run("rem_negdvs", REM, 32'd100, 32'hFFFF_FFF9, 5'd12, 32'd2, MDU_DIV_LAT);
    run("divu", DIVU, 32'd100, 32'd7, 5'd13, 32'd14, MDU_DIV_LAT);
    run("remu", REMU, 32'd100, 32'd7, 5'd14, 32'd2, MDU_DIV_LAT);
    run("divu_zero", DIVU, 32'h1234, 32'd0, 5'd15, 32'hFFFF_FFFF, 1);
    run("remu_zero", REMU, 32'h1234, 32'd0, 5'd16, 32'h1234, 1);
    run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1);
    run("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, 1);

    // flush in cycle 10 of a divide
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_funct3 = DIVU;
    bus.in_rs1 = 32'd1000;
    bus.in_rs2 = 32'd3;
    bus.in_rd = 5'd20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_busy", 32'(bus.busy), 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_ready", 32'(bus.in_ready), 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("flush_no_valid", 32'(seen), 0);
    chk("flush_result_kept", bus.out_result, 0);
    chk("flush_rd_kept", 32'(bus.out_rd), 18);
    run("mul_after_flush", MUL, 32'd3, 32'd5, 5'd21, 32'd15, MDU_MUL_LAT);

    // flush together with in_valid blocks the accept
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    bus.in_funct3 = DIVU;
    bus.in_rs1 = 32'd50;
    bus.in_rs2 = 32'd0;
    bus.in_rd = 5'd22;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    chk("flushacc_ready", 32'(bus.in_ready), 1);
    chk("flushacc_busy", 32'(bus.busy), 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("flushacc_no_valid", 32'(seen), 0);
    chk("flushacc_result_kept", bus.out_result, 15);

    // asynchronous reset in cycle 20 of a divide
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_funct3 = DIVU;
    bus.in_rs1 = 32'h7777;
    bus.in_rs2 = 32'd5;
    bus.in_rd = 5'd23;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("midrst_busy_before", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.in_ready), 1);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_result", bus.out_result, 0);
    chk("midrst_rd", 32'(bus.out_rd), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run("divu_after_rst", DIVU, 32'd9, 32'd3, 5'd24, 32'd3, MDU_DIV_LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
